pic_cpu_bus_master: RTL and testbench

//  CPU-side counterpart of the 8259 PIC: the bus master that drives the PIC's CS/RD/WR/A0

---
 rtl/pic_cpu_bus_master_if.sv | 35 +++
 rtl/pic_cpu_bus_master.sv | 106 ++++++++++
 tb/tb_pic_cpu_bus_master.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_cpu_bus_master_if.sv
// Host command port plus 8259 PIC bus signals between the CPU-side master and its peers.
// The master modport is the bus master; the slave modport is the host/PIC side.
interface pic_cpu_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic       cmd_a0;
  logic [7:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       int_enable;
  logic       INT;
  logic       INTA_n;
  logic [7:0] vector;
  logic       vector_valid;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       A0;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;

  modport master (
    input  cmd_valid, cmd_write, cmd_a0, cmd_data, int_enable, INT, data_in,
    output cmd_ready, rd_data, rd_valid, INTA_n, vector, vector_valid,
           CS_n, RD_n, WR_n, A0, data_out, data_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_a0, cmd_data, int_enable, INT, data_in,
    input  cmd_ready, rd_data, rd_valid, INTA_n, vector, vector_valid,
           CS_n, RD_n, WR_n, A0, data_out, data_oe
  );
endinterface

// File: rtl/pic_cpu_bus_master.sv
// CPU-side bus master for an 8259 PIC: single ICW/OCW writes, status reads,
// and the two-pulse INTA acknowledge with vector capture. All outputs registered.
module pic_cpu_bus_master #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned INTA_CYCLES   = 2,
  parameter int unsigned INTA_GAP      = 2
) (
  input  logic                clk,
  input  logic                rst,
  pic_cpu_bus_master_if.master bus
);

  localparam int unsigned MAX_A = (STROBE_CYCLES > INTA_CYCLES) ? STROBE_CYCLES : INTA_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > INTA_GAP) ? MAX_A : INTA_GAP;
  localparam int unsigned CW    = $clog2(MAX_C + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_MAX     = cnt_t'(MAX_C);
  localparam cnt_t STROBE_LAST = cnt_t'(STROBE_CYCLES - 1);
  localparam cnt_t INTA_LAST   = cnt_t'(INTA_CYCLES - 1);
  localparam cnt_t GAP_LAST    = cnt_t'(INTA_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, ACK1, GAP, ACK2, DONE
  } state_t;

  state_t state, state_next;
  cnt_t   cnt, cnt_next;
  logic   cmd_wr, wr_next;
  logic   accept;
  logic   access_next;
  logic   int_req;

  assign int_req = bus.INT && bus.int_enable;

  always_comb begin
    state_next = state;
    cnt_next   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    accept     = 1'b0;
    wr_next    = cmd_wr;
    unique case (state)
      IDLE: begin
        if (int_req) begin
          state_next = ACK1;
        end else if (bus.cmd_valid && bus.cmd_ready) begin
          accept     = 1'b1;
          wr_next    = bus.cmd_write;
          state_next = SETUP;
        end
      end
      SETUP:   state_next = STROBE;
      STROBE:  if (cnt == STROBE_LAST) state_next = HOLD;
      HOLD:    state_next = IDLE;
      ACK1:    if (cnt == INTA_LAST) state_next = GAP;
      GAP:     if (cnt == GAP_LAST) state_next = ACK2;
      ACK2:    if (cnt == INTA_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state_next != state) cnt_next = '0;
  end

  assign access_next = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      cmd_wr           <= 1'b0;
      bus.cmd_ready    <= 1'b0;
      bus.CS_n         <= 1'b1;
      bus.RD_n         <= 1'b1;
      bus.WR_n         <= 1'b1;
      bus.INTA_n       <= 1'b1;
      bus.A0           <= 1'b0;
      bus.data_out     <= '0;
      bus.data_oe      <= 1'b0;
      bus.rd_data      <= '0;
      bus.rd_valid     <= 1'b0;
      bus.vector       <= '0;
      bus.vector_valid <= 1'b0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      cmd_wr           <= wr_next;
      // Drop ready in an IDLE cycle that an already-pending interrupt will claim.
      bus.cmd_ready    <= (state_next == IDLE) && !int_req;
      bus.CS_n         <= !access_next;
      bus.RD_n         <= !((state_next == STROBE) && !wr_next);
      bus.WR_n         <= !((state_next == STROBE) && wr_next);
      bus.INTA_n       <= !((state_next == ACK1) || (state_next == ACK2));
      bus.data_oe      <= access_next && wr_next;
      bus.rd_valid     <= (state == HOLD) && (state_next == IDLE) && !cmd_wr;
      bus.vector_valid <= (state_next == DONE);
      if (accept) begin
        bus.A0 <= bus.cmd_a0;
        if (bus.cmd_write) bus.data_out <= bus.cmd_data;
      end
      if ((state == STROBE) && (state_next == HOLD) && !cmd_wr) bus.rd_data <= bus.data_in;
      if ((state == ACK2) && (state_next == DONE)) bus.vector <= bus.data_in;
    end
  end

endmodule

// File: tb/tb_pic_cpu_bus_master.sv
// Directed and randomized bench for pic_cpu_bus_master; expected bus waveforms are
// derived per transaction from the access/acknowledge timing rules.
module tb_pic_cpu_bus_master;
  localparam int S = 2;
  localparam int I = 2;
  localparam int G = 2;
  localparam int ACC_LEN = S + 3;
  localparam int INT_LEN = 2 * I + G + 1;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  pic_cpu_bus_master_if bus ();

  pic_cpu_bus_master #(
    .STROBE_CYCLES(S),
    .INTA_CYCLES  (I),
    .INTA_GAP     (G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic overlap;
    @(posedge clk);
    #1;
    overlap = (!bus.RD_n && !bus.WR_n) || (!bus.RD_n && !bus.INTA_n) || (!bus.WR_n && !bus.INTA_n);
    chk1("strobe_exclusive", overlap, 1'b0);
  endtask

  // One host access; lat is the expected number of edges from raising cmd_valid to CS_n low.
  task automatic do_cmd(input logic wr, input logic a0, input logic [7:0] data,
                        input logic [7:0] din, input int lat);
    int waited = 0;
    logic exp_oe;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_a0    = a0;
    bus.cmd_data  = data;
    bus.data_in   = ~din;
    do begin
      step();
      waited++;
    end while (bus.CS_n !== 1'b0 && waited < 40);
    bus.cmd_valid = 1'b0;
    bus.cmd_a0    = ~a0;
    bus.cmd_data  = ~data;
    if (bus.CS_n !== 1'b0) begin
      chk1("accept_timeout", bus.CS_n, 1'b0);
      return;
    end
    chk8("accept_latency", 8'(waited), 8'(lat));
    for (int k = 1; k <= ACC_LEN; k++) begin
      if (k > 1) step();
      bus.data_in = (k == S + 1) ? din : ~din;
      exp_oe = wr && (k <= S + 2);
      chk1("cs_n",      bus.CS_n,     !(k <= S + 2));
      chk1("wr_n",      bus.WR_n,     !(wr && k >= 2 && k <= S + 1));
      chk1("rd_n",      bus.RD_n,     !(!wr && k >= 2 && k <= S + 1));
      chk1("inta_n_cmd", bus.INTA_n,  1'b1);
      chk1("data_oe",   bus.data_oe,  exp_oe);
      chk1("rd_valid",  bus.rd_valid, !wr && (k == ACC_LEN));
      chk1("cmd_ready", bus.cmd_ready, (k == ACC_LEN) && !(bus.INT && bus.int_enable));
      if (k <= S + 2) chk1("a0", bus.A0, a0);
      if (exp_oe) chk8("data_out", bus.data_out, data);
      if (!wr && k == ACC_LEN) chk8("rd_data", bus.rd_data, din);
    end
  endtask

  // One acknowledge pair; INT / int_enable drop at the given offsets (0 or beyond end = never).
  task automatic do_int(input logic [7:0] vec, input int lat, input int drop_int_k, input int drop_en_k);
    int waited = 0;
    bus.INT        = 1'b1;
    bus.int_enable = 1'b1;
    bus.data_in    = ~vec;
    do begin
      step();
      waited++;
    end while (bus.INTA_n !== 1'b0 && waited < 40);
    if (bus.INTA_n !== 1'b0) begin
      chk1("inta_timeout", bus.INTA_n, 1'b0);
      return;
    end
    chk8("inta_latency", 8'(waited), 8'(lat));
    for (int k = 1; k <= INT_LEN; k++) begin
      if (k > 1) step();
      if (k == drop_int_k) bus.INT = 1'b0;
      if (k == drop_en_k) bus.int_enable = 1'b0;
      bus.data_in = (k == 2 * I + G) ? vec : ~vec;
      chk1("inta_n",       bus.INTA_n,       !(k <= I || (k > I + G && k <= 2 * I + G)));
      chk1("cs_n_int",     bus.CS_n,         1'b1);
      chk1("data_oe_int",  bus.data_oe,      1'b0);
      chk1("rd_n_int",     bus.RD_n,         1'b1);
      chk1("wr_n_int",     bus.WR_n,         1'b1);
      chk1("cmd_ready_int", bus.cmd_ready,   1'b0);
      chk1("vector_valid", bus.vector_valid, k == INT_LEN);
      if (k == INT_LEN) chk8("vector", bus.vector, vec);
    end
    step();
    chk1("inta_n_after",  bus.INTA_n,       1'b1);
    chk1("vv_after",      bus.vector_valid, 1'b0);
    chk1("ready_after",   bus.cmd_ready,    !(bus.INT && bus.int_enable));
  endtask

  initial begin
    int op;
    logic [7:0] r8;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_a0     = 1'b0;
    bus.cmd_data   = '0;
    bus.int_enable = 1'b0;
    bus.INT        = 1'b0;
    bus.data_in    = '0;
    #12;
    chk1("rst_cs_n", bus.CS_n, 1'b1);
    chk1("rst_rd_n", bus.RD_n, 1'b1);
    chk1("rst_wr_n", bus.WR_n, 1'b1);
    chk1("rst_inta_n", bus.INTA_n, 1'b1);
    chk1("rst_a0", bus.A0, 1'b0);
    chk8("rst_data_out", bus.data_out, 8'h00);
    chk1("rst_data_oe", bus.data_oe, 1'b0);
    chk8("rst_rd_data", bus.rd_data, 8'h00);
    chk8("rst_vector", bus.vector, 8'h00);
    chk1("rst_rd_valid", bus.rd_valid, 1'b0);
    chk1("rst_vector_valid", bus.vector_valid, 1'b0);
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("ready_at_release", bus.cmd_ready, 1'b0);
    step();
    chk1("ready_one_cycle_later", bus.cmd_ready, 1'b1);

    do_cmd(1'b1, 1'b0, 8'h13, 8'h00, 1);
    do_cmd(1'b0, 1'b1, 8'h00, 8'hA5, 1);
    do_int(8'h24, 1, 1, 0);

    // Command and interrupt arrive together: acknowledge first, then the write exactly once.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_a0    = 1'b1;
    bus.cmd_data  = 8'h5A;
    do_int(8'h66, 1, 1, 0);
    do_cmd(1'b1, 1'b1, 8'h5A, 8'h00, 1);
    repeat (3) begin
      step();
      chk1("no_duplicate", bus.CS_n, 1'b1);
    end

    bus.int_enable = 1'b0;
    bus.INT        = 1'b1;
    do_cmd(1'b1, 1'b0, 8'hC3, 8'h00, 1);
    repeat (3) begin
      step();
      chk1("masked_inta_n", bus.INTA_n, 1'b1);
    end
    do_int(8'h5C, 1, 1, 2);
    bus.int_enable = 1'b1;

    // INT held through DONE starts a second acknowledge pair.
    do_int(8'h31, 1, 99, 0);
    do_int(8'h42, 1, 1, 0);

    for (int n = 0; n < 24; n++) begin
      op = int'($urandom_range(0, 3));
      r8 = 8'($urandom);
      case (op)
        0: do_cmd(1'b1, 1'($urandom), r8, 8'h00, 1);
        1: do_cmd(1'b0, 1'($urandom), 8'h00, r8, 1);
        2: begin
          do_int(r8, 1, int'($urandom_range(1, INT_LEN)), int'($urandom_range(0, INT_LEN + 2)));
          bus.INT        = 1'b0;
          bus.int_enable = 1'b1;
        end
        default: begin
          bus.int_enable = 1'b0;
          bus.INT        = 1'b1;
          repeat (3) begin
            step();
            chk1("rand_masked_inta_n", bus.INTA_n, 1'b1);
            chk1("rand_masked_ready", bus.cmd_ready, 1'b1);
          end
          bus.INT        = 1'b0;
          bus.int_enable = 1'b1;
        end
      endcase
    end

    // Asynchronous reset in the middle of a write strobe.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_a0    = 1'b1;
    bus.cmd_data  = 8'h77;
    step();
    chk1("pre_rst_cs_n", bus.CS_n, 1'b0);
    bus.cmd_valid = 1'b0;
    step();
    chk1("pre_rst_wr_n", bus.WR_n, 1'b0);
    rst = 1'b1;
    #1;
    chk1("async_cs_n", bus.CS_n, 1'b1);
    chk1("async_wr_n", bus.WR_n, 1'b1);
    chk1("async_data_oe", bus.data_oe, 1'b0);
    chk8("async_data_out", bus.data_out, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      step();
      chk1("post_rst_rd_valid", bus.rd_valid, 1'b0);
      chk1("post_rst_vector_valid", bus.vector_valid, 1'b0);
      chk1("post_rst_cs_n", bus.CS_n, 1'b1);
      chk1("post_rst_inta_n", bus.INTA_n, 1'b1);
    end
    chk1("post_rst_ready", bus.cmd_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
